// File: rtl/config_rd_arbiter.sv
// Round-robin arbiter sharing one config-memory read port among NUM_REQ requesters.
// Issues at most one tagged read per cycle and returns a per-requester data-valid strobe.
module config_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 66
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic                      pause_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvld_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_rdEn_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] rvld_r;
    logic               rden_r;
    logic [ADDR_W-1:0]  maddr_r;
    logic               busy_r;
    logic [PTR_W-1:0]   rr_ptr_r;

    logic [NUM_REQ-1:0] elig_s;
    logic               found_s;
    logic               grant_s;
    logic [PTR_W-1:0]   winner_s;
    logic [PTR_W-1:0]   rr_nxt_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W-1:0]   cand_s;
    logic [ADDR_W-1:0]  addr_arr_s [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
        assign addr_arr_s[k] = addr_i[k*ADDR_W +: ADDR_W];
    end

    // A requester holding a grant this cycle is masked so its still-high req is not re-granted.
    assign elig_s = req_i & ~gnt_r;

    // Round-robin search: first eligible index at or above rr_ptr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        sum_s    = '0;
        cand_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[PTR_W-1:0];
            if (!found_s && elig_s[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // Pointer advance and grant qualification.
    always_comb begin
        grant_s = found_s & ~pause_i;
        if (winner_s == PTR_W'(NUM_REQ-1)) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = winner_s + 1'b1;
        end
    end

    // Grant, memory request and return-strobe registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_r    <= '0;
            rvld_r   <= '0;
            rden_r   <= 1'b0;
            maddr_r  <= '0;
            busy_r   <= 1'b0;
            rr_ptr_r <= '0;
        end else begin
            rvld_r <= gnt_r;
            busy_r <= grant_s | (|gnt_r);
            if (grant_s) begin
                gnt_r    <= ONE_HOT0 << winner_s;
                rden_r   <= 1'b1;
                maddr_r  <= addr_arr_s[winner_s];
                rr_ptr_r <= rr_nxt_s;
            end else begin
                gnt_r    <= '0;
                rden_r   <= 1'b0;
            end
        end
    end

    assign gnt_o      = gnt_r;
    assign rvld_o     = rvld_r;
    assign mem_rdEn_o = rden_r;
    assign mem_addr_o = maddr_r;
    assign busy_o     = busy_r;
    assign rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_config_rd_arbiter.sv
// Self-checking bench for config_rd_arbiter: per-cycle vector table plus a read-data scoreboard
// and a hand-written mid-read reset sequence.
module tb_config_rd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 66;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr = '0;
    logic                      pause = 1'b0;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvld;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_rden;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_rdata = '0;
    logic                      busy;

    config_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .pause_i(pause),
        .gnt_o(gnt), .rvld_o(rvld), .rdata_o(rdata), .mem_rdEn_o(mem_rden),
        .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 8'h2A) return 66'h1234;
        return {2'b11, a, 48'h0000_0000_BEEF, a};
    endfunction

    // Memory model: registered output, one cycle after the read enable.
    always @(posedge clk) begin
        if (mem_rden) mem_rdata <= mem_word(mem_addr);
    end

    typedef struct {
        logic        rst;
        logic        pause;
        logic [3:0]  req;
        logic [31:0] addr;
        logic [3:0]  gnt;
        logic [3:0]  rvld;
        logic        rden;
        logic [7:0]  maddr;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [3:0]        onehot;
        logic [DATA_W-1:0] data;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] A0 = 32'h40_21_33_2A;
    localparam logic [31:0] A1 = 32'h40_55_33_2A;

    function automatic vec_t v(input logic r, input logic p, input logic [3:0] rq, input logic [31:0] ad,
                               input logic [3:0] g, input logic [3:0] rv, input logic re,
                               input logic [7:0] ma, input logic b);
        vec_t x;
        x.rst = r; x.pause = p; x.req = rq; x.addr = ad;
        x.gnt = g; x.rvld = rv; x.rden = re; x.maddr = ma; x.busy = b;
        return x;
    endfunction

    task automatic cmp(input string what, input int row, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", what, row, got, want);
        end
    endtask

    task automatic check(input int row, input logic [3:0] eg, input logic [3:0] erv, input logic ere,
                         input logic [7:0] ema, input logic eb, input logic push);
        sb_t it;
        cmp("gnt", row, DATA_W'(gnt), DATA_W'(eg));
        cmp("rvld", row, DATA_W'(rvld), DATA_W'(erv));
        cmp("mem_rden", row, DATA_W'(mem_rden), DATA_W'(ere));
        cmp("mem_addr", row, DATA_W'(mem_addr), DATA_W'(ema));
        cmp("busy", row, DATA_W'(busy), DATA_W'(eb));
        if (rvld != 4'b0000) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_rvld row %0d: got %b want none", row, rvld);
            end else begin
                it = sbq.pop_front();
                cmp("sb_rvld", row, DATA_W'(rvld), DATA_W'(it.onehot));
                cmp("sb_rdata", row, rdata, it.data);
            end
        end
        if (push && eg != 4'b0000) begin
            it.onehot = eg;
            it.data   = mem_word(ema);
            sbq.push_back(it);
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic [31:0] ad);
        @(negedge clk);
        req  = rq;
        addr = ad;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, pause, req, addr, gnt, rvld, rden, maddr, busy
        tbl.push_back(v(1'b1, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'b0001, A0, 4'b0001, 4'b0000, 1'b1, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0001, A0, 4'b0000, 4'b0001, 1'b0, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h2A, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h2A, 1'b0));
        // full contention from reset
        tbl.push_back(v(1'b1, 1'b0, 4'b1111, A0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'b1111, A0, 4'b0001, 4'b0000, 1'b1, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b1111, A0, 4'b0010, 4'b0001, 1'b1, 8'h33, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b1110, A0, 4'b0100, 4'b0010, 1'b1, 8'h21, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b1100, A0, 4'b1000, 4'b0100, 1'b1, 8'h40, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b1000, A0, 4'b0000, 4'b1000, 1'b0, 8'h40, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h40, 1'b0));
        // persistent requester 2, address changes between grants
        tbl.push_back(v(1'b0, 1'b0, 4'b0100, A0, 4'b0100, 4'b0000, 1'b1, 8'h21, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0100, A1, 4'b0000, 4'b0100, 1'b0, 8'h21, 1'b1));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(v(1'b0, 1'b0, 4'b0100, A1, 4'b0100, 4'b0000, 1'b1, 8'h55, 1'b1));
            tbl.push_back(v(1'b0, 1'b0, 4'b0100, A1, 4'b0000, 4'b0100, 1'b0, 8'h55, 1'b1));
        end
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A1, 4'b0000, 4'b0000, 1'b0, 8'h55, 1'b0));
        // wrap-around from pointer 3
        tbl.push_back(v(1'b0, 1'b0, 4'b1001, A0, 4'b1000, 4'b0000, 1'b1, 8'h40, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b1001, A0, 4'b0001, 4'b1000, 1'b1, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0001, A0, 4'b0000, 4'b0001, 1'b0, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h2A, 1'b0));
        // pause after grant to requester 1
        tbl.push_back(v(1'b0, 1'b0, 4'b0110, A0, 4'b0010, 4'b0000, 1'b1, 8'h33, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 4'b0110, A0, 4'b0000, 4'b0010, 1'b0, 8'h33, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, 4'b0100, A0, 4'b0000, 4'b0000, 1'b0, 8'h33, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'b0101, A0, 4'b0100, 4'b0000, 1'b1, 8'h21, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0101, A0, 4'b0001, 4'b0100, 1'b1, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0001, A0, 4'b0000, 4'b0001, 1'b0, 8'h2A, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'b0000, A0, 4'b0000, 4'b0000, 1'b0, 8'h2A, 1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            rst   = tbl[r].rst;
            pause = tbl[r].pause;
            req   = tbl[r].req;
            addr  = tbl[r].addr;
            if (tbl[r].rst) sbq.delete();
            @(posedge clk);
            #1;
            check(r, tbl[r].gnt, tbl[r].rvld, tbl[r].rden, tbl[r].maddr, tbl[r].busy, 1'b1);
        end

        // Reset mid-read: pointer is 1, so requester 2 is granted first.
        step(4'b1100, A0);
        check(100, 4'b0100, 4'b0000, 1'b1, 8'h21, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check(101, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
        sbq.delete();
        @(posedge clk);
        #1;
        check(102, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check(103, 4'b0100, 4'b0000, 1'b1, 8'h21, 1'b1, 1'b1);
        step(4'b1100, A0);
        check(104, 4'b1000, 4'b0100, 1'b1, 8'h40, 1'b1, 1'b1);
        step(4'b1000, A0);
        check(105, 4'b0000, 4'b1000, 1'b0, 8'h40, 1'b1, 1'b1);
        step(4'b0000, A0);
        check(106, 4'b0000, 4'b0000, 1'b0, 8'h40, 1'b0, 1'b1);

        cmp("sb_drained", 107, DATA_W'(sbq.size()), DATA_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_rd_arbiter.md
# config_rd_arbiter

Round-robin arbiter that shares one read port of the neuron configuration memory among up to NUM_REQ requesters, such as the neuron controller, the STDP learning unit and the debug/readback path. It sits directly in front of a config memory read port (read enable, address, registered data out with one-cycle latency). It issues at most one read per cycle, tags each read with its requester, and returns a per-requester data-valid strobe. A pause input blocks new grants while the memory contents are reloaded.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, config memory address width (NURN_CNT_BIT_WIDTH)
- DATA_W, 66, config memory word width (NurnType+RandTh+Th_Mask+RstPot+SpikeAER)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NUM_REQ  per-requester read request, level
- addr_i  in  NUM_REQ*ADDR_W  per-requester address, requester k at bits [k*ADDR_W +: ADDR_W]
- pause_i  in  1  blocks new grants while high
- gnt_o  out  NUM_REQ  one-hot grant pulse, registered
- rvld_o  out  NUM_REQ  one-hot read-data-valid pulse, registered
- rdata_o  out  DATA_W  read data, broadcast to all requesters, valid where rvld_o≠0
- mem_rdEn_o  out  1  memory read enable, registered
- mem_addr_o  out  ADDR_W  memory read address, registered
- mem_rdata_i  in  DATA_W  memory output register, valid one cycle after mem_rdEn_o
- busy_o  out  1  high while a read is in flight (mem_rdEn_o | any rvld_o)

## Operation
- Eligible set each cycle: req_i & ~gnt_o. A requester that holds a grant this cycle is excluded. This prevents a double grant, because the requester drops req_i only at the edge after it sees gnt_o.
- If pause_i=0 and the eligible set ≠0, the winner is the first eligible index at or above rr_ptr, wrapping modulo NUM_REQ.
- At the edge:
  - gnt_o <= onehot(winner).
  - mem_rdEn_o <= 1.
  - mem_addr_o <= addr_i[winner].
  - rr_ptr <= (winner+1) mod NUM_REQ.
- Otherwise at the edge: gnt_o <= 0, mem_rdEn_o <= 0, mem_addr_o holds its value, rr_ptr holds.
- Return pipeline: rvld_o <= gnt_o each edge. rdata_o = mem_rdata_i, passed through combinationally.
- A requester that keeps req_i high after its grant is treated as making a new request. Its maximum rate is one grant every 2 cycles. Aggregate throughput with ≥2 active requesters is one read per cycle.
- pause_i affects only new grants. A read already issued (mem_rdEn_o=1) still completes, and rvld_o still fires.
- addr_i for the winner is sampled only at the grant edge. The requester may change addr_i after it sees gnt_o.
- Reset values: gnt_o=0, rvld_o=0, mem_rdEn_o=0, mem_addr_o=0, rr_ptr=0, busy_o=0.
- Reset mid-operation: in-flight reads are discarded and no rvld_o is produced for them. After release, arbitration restarts from index 0.

## Timing
- Edge E0 samples req_i. In the cycle after E0: gnt_o[k]=1, mem_rdEn_o=1, mem_addr_o valid.
- Edge E1: the memory latches the data. In the cycle after E1: rvld_o[k]=1 and rdata_o valid.
- Latency from request sampled to data valid: 2 cycles. From a gnt_o pulse to rvld_o: 1 cycle.
- gnt_o and rvld_o are each high for exactly one cycle per read, and each has at most one bit set.
- Simultaneous requests: exactly one winner per cycle, chosen by rr_ptr. Losing requesters keep req_i high until they are granted.
- Fairness: with all requesters continuously requesting, each is granted at least once per NUM_REQ cycles.
- pause_i is sampled at the same edge as req_i. If pause_i rises in the same cycle as a request, no grant is issued at that edge.

## Test plan
- Single request: req_i=4'b0001, addr_i[0]=8'h2A, memory word at 0x2A = DATA_W'h1234.
  - Required: gnt_o=0001 and mem_addr_o=2A in cycle 1; rvld_o=0001 and rdata_o=1234 in cycle 2.
  - No second grant occurs when req_i drops on the gnt_o edge.
- Full contention: req_i=4'b1111 held continuously from reset, each requester dropping req_i after its own grant.
  - Required grant order: 0001, 0010, 0100, 1000, one per cycle.
  - Each requester receives rvld_o one cycle after its grant, with data from its own address.
- Persistent requester: requester 2 holds req_i high for 10 cycles and is alone.
  - Required: grants on alternate cycles (5 grants) and 5 rvld_o pulses.
- Pause: pause_i=1 in the cycle after the grant to requester 1.
  - Required: rvld_o=0010 still fires; no new gnt_o while paused; arbitration resumes at index 2 after pause_i falls.
- Reset mid-read: assert rst_i during the cycle when mem_rdEn_o=1.
  - Required: all outputs 0 immediately; no rvld_o after release; the first post-reset grant goes to the lowest-indexed active requester.
- Wrap-around: rr_ptr=3 (after granting requester 2), then req_i=4'b1001.
  - Required: grant 1000 first, then 0001.
